// File: rtl/clk_rst_pkg.sv
// Shared types and counter-width helpers for the clock-enable / reset conditioner.
package clk_rst_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Phase accumulator width: room for acc + 16*baud before the wrap subtraction.
  function automatic int acc_w(input int clk_hz, input int baud);
    return $clog2(clk_hz + 16 * baud) + 1;
  endfunction

endpackage

// File: rtl/clk_rst_gen_btn_sync_debounce.sv
// Two-flop synchroniser plus stability counter for the active-low reset button.
module btn_sync_debounce
  import clk_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_rst_n,
  output logic btn_db
);

  localparam int              DB_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            btn_db_q, btn_db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_rst_n;
      sync2_q  <= sync1_q;
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn_db = btn_db_q;

endmodule

// File: rtl/clk_rst_gen.sv
// Board reset conditioner: debounced button + power-on stretch into sys_rst,
// CPU clock-enable divider and drift-free 16x/1x UART baud ticks from one clock.
module clk_rst_gen
  import clk_rst_pkg::*;
#(
  parameter int CLK_HZ          = 27000000,
  parameter int BAUD            = 115200,
  parameter int CPU_DIV         = 1,
  parameter int POR_CYCLES      = 1024,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_rst_n,
  output logic sys_rst,
  output logic cpu_ce,
  output logic baud_tick16,
  output logic baud_tick,
  output logic rst_by_btn
);

  localparam int POR_W = cnt_w(POR_CYCLES);
  localparam int DIV_W = cnt_w(CPU_DIV);
  localparam int ACC_W = acc_w(CLK_HZ, BAUD);

  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CPU_DIV - 1);
  localparam logic [ACC_W-1:0] ACC_INC  = ACC_W'(16 * BAUD);
  localparam logic [ACC_W-1:0] ACC_MOD  = ACC_W'(CLK_HZ);

  if (BAUD * 16 >= CLK_HZ || CPU_DIV < 1 || POR_CYCLES < 1 || DEBOUNCE_CYCLES < 1)
  begin : g_bad_params
    $error("clk_rst_gen: illegal parameter set");
  end

  logic btn_db;

  btn_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn_rst_n(btn_rst_n),
    .btn_db   (btn_db)
  );

  state_e           state_q, state_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  logic             sys_rst_q, sys_rst_d;
  logic             rst_by_btn_q, rst_by_btn_d;
  logic [DIV_W-1:0] cpu_cnt_q, cpu_cnt_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic             tick16_q, tick16_d;
  logic [3:0]       sub_cnt_q, sub_cnt_d;
  logic             tick_q, tick_d;
  logic             run_d;

  always_comb begin
    state_d      = state_q;
    por_cnt_d    = por_cnt_q;
    rst_by_btn_d = rst_by_btn_q;
    unique case (state_q)
      HOLD: begin
        if (!btn_db) begin
          por_cnt_d = '0;
        end else if (por_cnt_q == POR_LAST) begin
          state_d   = RUN;
          por_cnt_d = '0;
        end else begin
          por_cnt_d = por_cnt_q + POR_W'(1);
        end
      end
      RUN: begin
        if (!btn_db) begin
          state_d      = HOLD;
          por_cnt_d    = '0;
          rst_by_btn_d = 1'b1;
        end
      end
    endcase
    sys_rst_d = (state_d == HOLD);
  end

  // Enables and ticks are computed from the next state so they are never
  // asserted in a cycle where sys_rst is high.
  always_comb begin
    run_d     = (state_d == RUN);
    cpu_cnt_d = '0;
    if (run_d && state_q == RUN) begin
      cpu_cnt_d = (cpu_cnt_q == DIV_LAST) ? '0 : cpu_cnt_q + DIV_W'(1);
    end
    cpu_ce_d = run_d && (cpu_cnt_d == DIV_LAST);

    acc_sum   = acc_q + ACC_INC;
    acc_d     = '0;
    tick16_d  = 1'b0;
    sub_cnt_d = '0;
    tick_d    = 1'b0;
    if (run_d) begin
      if (acc_sum >= ACC_MOD) begin
        acc_d    = acc_sum - ACC_MOD;
        tick16_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
      sub_cnt_d = tick16_d ? sub_cnt_q + 4'd1 : sub_cnt_q;
      tick_d    = tick16_d && (sub_cnt_q == 4'd15);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      por_cnt_q    <= '0;
      sys_rst_q    <= 1'b1;
      rst_by_btn_q <= 1'b0;
      cpu_cnt_q    <= '0;
      cpu_ce_q     <= 1'b0;
      acc_q        <= '0;
      tick16_q     <= 1'b0;
      sub_cnt_q    <= '0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      por_cnt_q    <= por_cnt_d;
      sys_rst_q    <= sys_rst_d;
      rst_by_btn_q <= rst_by_btn_d;
      cpu_cnt_q    <= cpu_cnt_d;
      cpu_ce_q     <= cpu_ce_d;
      acc_q        <= acc_d;
      tick16_q     <= tick16_d;
      sub_cnt_q    <= sub_cnt_d;
      tick_q       <= tick_d;
    end
  end

  assign sys_rst     = sys_rst_q;
  assign cpu_ce      = cpu_ce_q;
  assign baud_tick16 = tick16_q;
  assign baud_tick   = tick_q;
  assign rst_by_btn  = rst_by_btn_q;

endmodule

// File: tb/tb_clk_rst_gen.sv
// Directed bench for clk_rst_gen: a per-cycle vector table for reset/POR/button
// timing, plus hand sequences for baud counts, long presses and mid-run reset.
module tb_clk_rst_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_rst_n = 1'b1;

  logic sys_rst, cpu_ce, baud_tick16, baud_tick, rst_by_btn;
  logic sys_rst1, cpu_ce1, tick16_1, tick_1, rbb1;

  always #5 clk = ~clk;

  clk_rst_gen #(
    .CLK_HZ(1000), .BAUD(50), .CPU_DIV(3), .POR_CYCLES(8), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_rst_n(btn_rst_n), .sys_rst(sys_rst),
    .cpu_ce(cpu_ce), .baud_tick16(baud_tick16), .baud_tick(baud_tick),
    .rst_by_btn(rst_by_btn)
  );

  // Same block with CPU_DIV=1, driven by the same inputs.
  clk_rst_gen #(
    .CLK_HZ(1000), .BAUD(50), .CPU_DIV(1), .POR_CYCLES(8), .DEBOUNCE_CYCLES(4)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_rst_n(btn_rst_n), .sys_rst(sys_rst1),
    .cpu_ce(cpu_ce1), .baud_tick16(tick16_1), .baud_tick(tick_1),
    .rst_by_btn(rbb1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic rst;
    logic btn;
    logic sys_rst;
    logic cpu_ce;
    logic ce1;
    logic rbb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge; sample outputs 1 time unit after the rising edge.
  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst       = r;
    btn_rst_n = b;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic b, input logic s,
                              input logic ce, input logic ce1, input logic rbb);
    vecs.push_back('{rst: r, btn: b, sys_rst: s, cpu_ce: ce, ce1: ce1, rbb: rbb});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at, fall_at, hold_viol;
    int c16, c1, cce, cce1, c16_1, c1_1, coinc_bad;
    bit found;

    // ---- Scenario 1: reset then POR stretch, CPU_DIV=3 enable phase ----
    for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0);   // edge 8: RUN cycle 1
    add(0, 1, 0, 0, 1, 0);   // RUN cycle 2
    add(0, 1, 0, 1, 1, 0);   // RUN cycle 3: first cpu_ce
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0);   // cycle 6
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0);   // cycle 9
    // ---- Scenario 3a: 3-cycle glitch is ignored (RUN cycles 10..17) ----
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0);   // cycle 12
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0);   // cycle 15
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0);
    // ---- Scenario 3b: 10-cycle press; btn_db falls on edge 6, sys_rst on edge 7 ----
    add(0, 0, 0, 1, 1, 0);   // p1, cycle 18
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0);   // p4, cycle 21
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0);   // p6
    for (int p = 7; p <= 10; p++) add(0, 0, 1, 0, 0, 1);
    // release on edge 11: btn_db rises on edge 16, POR runs edges 17..24
    for (int r = 11; r <= 23; r++) add(0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1);   // edge 24: RUN cycle 1
    add(0, 1, 0, 0, 1, 1);
    add(0, 1, 0, 1, 1, 1);   // RUN cycle 3

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn);
      check($sformatf("vec%0d sys_rst", i), sys_rst, vecs[i].sys_rst);
      check($sformatf("vec%0d cpu_ce", i), cpu_ce, vecs[i].cpu_ce);
      check($sformatf("vec%0d cpu_ce_div1", i), cpu_ce1, vecs[i].ce1);
      check($sformatf("vec%0d rst_by_btn", i), rst_by_btn, vecs[i].rbb);
      if (vecs[i].sys_rst) begin
        check($sformatf("vec%0d tick16_in_hold", i), baud_tick16, 0);
        check($sformatf("vec%0d tick_in_hold", i), baud_tick, 0);
      end
    end

    // ---- Scenario 2: baud tick counts over 1000 RUN cycles ----
    for (int i = 0; i < 3; i++) step(1, 1);
    check("s2 reset rst_by_btn", rst_by_btn, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 1);
      if (sys_rst == 1'b0) found = 1;
    end
    check("s2 sys_rst fell within budget", found, 1);
    c16 = 0; c1 = 0; cce = 0; cce1 = 0; c16_1 = 0; c1_1 = 0; coinc_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) step(0, 1);
      c16   += int'(baud_tick16);
      c1    += int'(baud_tick);
      cce   += int'(cpu_ce);
      cce1  += int'(cpu_ce1);
      c16_1 += int'(tick16_1);
      c1_1  += int'(tick_1);
      if (baud_tick && !baud_tick16) coinc_bad++;
    end
    check("s2 tick16 count", c16, 800);
    check("s2 tick count", c1, 50);
    check("s2 tick without tick16", coinc_bad, 0);
    check("s2 cpu_ce count div3", cce, 333);
    check("s2 cpu_ce count div1", cce1, 1000);
    check("s2 tick16 count div1 dut", c16_1, 800);
    check("s2 tick count div1 dut", c1_1, 50);

    // ---- Scenario 4: 50-cycle press then release ----
    rise_at = 0; hold_viol = 0;
    for (int p = 1; p <= 50; p++) begin
      step(0, 0);
      if (sys_rst && rise_at == 0) rise_at = p;
      if (rise_at != 0 && !sys_rst) hold_viol++;
      if (sys_rst && (cpu_ce || baud_tick16 || baud_tick)) hold_viol++;
    end
    check("s4 sys_rst rise edge", rise_at, 7);
    fall_at = 0;
    for (int r = 1; r <= 30 && fall_at == 0; r++) begin
      step(0, 1);
      if (!sys_rst) fall_at = r;
      else if (cpu_ce || baud_tick16 || baud_tick || cpu_ce1) hold_viol++;
    end
    check("s4 sys_rst fall edge after release", fall_at, 14);
    check("s4 violations during HOLD", hold_viol, 0);
    check("s4 rst_by_btn", rst_by_btn, 1);

    // ---- Scenario 5: rst mid-RUN while accumulator is busy and button debouncing ----
    for (int i = 0; i < 3; i++) step(0, 1);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("s5 sys_rst", sys_rst, 1);
    check("s5 cpu_ce", cpu_ce, 0);
    check("s5 tick16", baud_tick16, 0);
    check("s5 tick", baud_tick, 0);
    check("s5 rst_by_btn", rst_by_btn, 0);
    check("s5 rst_by_btn div1", rbb1, 0);
    check("s5 cpu_ce div1", cpu_ce1, 0);
    for (int k = 1; k <= 13; k++) begin
      step(0, 1);
      check($sformatf("s5 k%0d sys_rst", k), sys_rst, (k < 8) ? 1 : 0);
      check($sformatf("s5 k%0d cpu_ce", k), cpu_ce, (k == 10 || k == 13) ? 1 : 0);
      check($sformatf("s5 k%0d cpu_ce_div1", k), cpu_ce1, (k >= 8) ? 1 : 0);
      check($sformatf("s5 k%0d tick16", k), baud_tick16, (k == 9) ? 1 : ((k < 9) ? 0 : baud_tick16));
      check($sformatf("s5 k%0d rst_by_btn", k), rst_by_btn, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
